// File: rtl/count_capture_pkg.sv
// Shared types and widths for the count_capture stage.
package count_capture_pkg;

  localparam int ENTRY_W = 18;
  localparam int DROP_W  = 8;

  typedef struct packed {
    logic [1:0]  cc;
    logic [15:0] count;
  } cap_entry_t;

endpackage

// File: rtl/cap_fifo.sv
// Small synchronous FIFO holding capture entries, with valid/ready read side.
module cap_fifo
  import count_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  cap_entry_t               wr_data,
  input  logic                     out_ready,
  output cap_entry_t               rd_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cap_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [LW-1:0]   level_next;
  logic            full_reg;
  logic            push;

  assign out_valid = (level_reg != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = push_req & (~full_reg | pop);

  always_comb begin
    level_next = level_reg;
    if (push && !pop)
      level_next = level_reg + LW'(1);
    else if (pop && !push)
      level_next = level_reg - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == LW'(DEPTH));
    end
  end

  // Storage is not reset; stale contents are hidden by masking the read port.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
  end

  assign rd_data = out_valid ? mem[rd_ptr_reg] : '0;
  assign level   = level_reg;
  assign full    = full_reg;

endmodule

// File: rtl/count_capture.sv
// Snapshots {cc, count} on a trig rising edge or cc change into a FIFO,
// counting captures lost to overrun.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter bit CC_EVENT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              count,
  input  logic [1:0]               cc,
  input  logic                     trig,
  input  logic                     clr_ovf,
  output logic [ENTRY_W-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  logic        trig_q;
  logic [1:0]  cc_q;
  logic        armed;
  logic        trig_ev;
  logic        cc_ev;
  logic        cap;
  logic        pop;
  logic        drop;
  logic        overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;
  cap_entry_t  wr_entry;
  cap_entry_t  head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
      cc_q   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      trig_q <= trig;
      cc_q   <= cc;
      armed  <= 1'b1;
    end
  end

  // Disarmed on the first cycle so loading cc_q cannot look like a change.
  assign trig_ev = trig & ~trig_q;
  assign cc_ev   = CC_EVENT & armed & (cc != cc_q);
  assign cap     = trig_ev | cc_ev;

  assign wr_entry.cc    = cc;
  assign wr_entry.count = count;

  cap_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (cap),
    .wr_data   (wr_entry),
    .out_ready (out_ready),
    .rd_data   (head),
    .out_valid (out_valid),
    .level     (level),
    .full      (full),
    .pop       (pop)
  );

  assign drop = cap & full & ~pop;

  // A drop coinciding with a clear wins, leaving a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clr_ovf)
        drop_cnt_reg <= DROP_W'(1);
      else if (drop_cnt_reg != '1)
        drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
    end else if (clr_ovf) begin
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end
  end

  assign out_data = head;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: doc/count_capture.md
# count_capture

Timestamp-capture stage downstream of the `test` counter top. On a trigger rising edge, or on any change of the 2-bit `cc` status bus, it snapshots `{cc, count}` into a small FIFO. The FIFO presents entries to a consumer over a valid/ready handshake. Lost captures are counted and flagged so software can detect overrun.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `CC_EVENT`, 1: 1 = a `cc` change also triggers a capture; 0 = only `trig` captures.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `count` in 16: free-running count from the upstream counter.
- `cc` in 2: status bus from the upstream counter.
- `trig` in 1: capture request, synchronous to `clk`, level; its rising edge is detected internally.
- `clr_ovf` in 1: single-cycle pulse; clears `overflow` and `drop_cnt`.
- `out_data` out 18: head entry `{cc[1:0], count[15:0]}`.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: consumer accepts the head entry.
- `level` out $clog2(DEPTH)+1: current number of stored entries.
- `full` out 1: `level == DEPTH`.
- `overflow` out 1: sticky flag; a capture was dropped.
- `drop_cnt` out 8: number of dropped captures, saturates at 255.

## Operation
- Edge detect: `trig_q` is the registered copy of `trig`. `trig_ev = trig & ~trig_q`.
- Change detect: `cc_q` is the registered copy of `cc`. `cc_ev = CC_EVENT & armed & (cc != cc_q)`.
- Arming: `armed` is 0 out of reset and becomes 1 on the first clock after reset. The first cycle therefore only loads `cc_q` and produces no spurious event.
- Capture: `cap = trig_ev | cc_ev`. A simultaneous `trig_ev` and `cc_ev` produce one capture only.
  - The entry stored is the current-cycle `{cc, count}`, not the registered values.
- Push: occurs when `cap & (~full | pop)`. If the FIFO is full and a pop happens in the same cycle, the push is accepted and `level` stays at DEPTH.
- Pop: occurs when `out_valid & out_ready`.
- Drop: occurs when `cap & full & ~pop`.
  - Sets `overflow`.
  - Increments `drop_cnt`, saturating at 255 (no wrap).
- `clr_ovf`: clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the drop wins: `overflow` = 1 and `drop_cnt` = 1.
- Level update:
  - push only: `level` + 1
  - pop only: `level` − 1
  - push and pop together: `level` unchanged
- Pointers: read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Empty handshake: when `level == 0`, `out_valid` = 0. `out_ready` is ignored while empty, so there is no underflow.
- Data stability: `out_data` is stable while `out_valid & ~out_ready`. `out_data` is don't-care when `out_valid` = 0.

## Timing
- Reset values (asynchronous): `out_valid` = 0, `level` = 0, `full` = 0, `overflow` = 0, `drop_cnt` = 0, pointers = 0, `trig_q` = 0, `cc_q` = 0, `armed` = 0. `out_data` reads as 0 (storage is cleared or masked).
- Capture latency: a `trig` rising edge at cycle N gives `out_valid` = 1 at N+1 with `count` sampled at N.
- Handshake: a pop at cycle N presents the next entry, if any, at N+1. Back-to-back pops are sustained at one entry per cycle.
- Flags: `full` and `level` are registered and update in the cycle after a push or pop.
- Reset mid-operation: all stored entries are lost, outputs return to their reset values immediately, and there is no event on the first cycle after release.

## Structure
- Package `count_capture_pkg`:
  - `ENTRY_W = 18`
  - typedef `cap_entry_t` = struct `{logic [1:0] cc; logic [15:0] count;}`
  - `DROP_W = 8`
- Sub-module `cap_fifo`: synchronous FIFO with parameter DEPTH.
  - Holds the storage, pointers, `level`/`full`, and push/pop handling.
  - Takes `clk` and `rst` with the same reset semantics as `count_capture`.
- Top `count_capture` contains the edge/change detection, the arming logic, and the overflow/drop logic.

## Test plan
- Reset release with `cc` = 2'b10 and `trig` = 0 → no capture; `level` = 0, `out_valid` = 0 for 10 cycles.
- `trig` pulse at `count` = 16'h0040, `cc` = 2'b00, with `out_ready` = 1 → the next cycle shows `out_valid` = 1 and `out_data` = 18'h00040; the cycle after that shows `level` = 0.
- `trig` held high for 5 cycles → exactly one entry is stored. Then `cc` goes 00→01 at `count` = 16'h0100 → a second entry with `out_data` = 18'h10100.
- `out_ready` = 0 and 6 `trig` edges with DEPTH = 4 → `level` = 4, `full` = 1, `overflow` = 1, `drop_cnt` = 2. Draining 4 entries returns the first four counts in order.
- FIFO full, with a `trig` edge and a pop in the same cycle → no drop; `level` stays 4 and the new entry appears last on drain.
- 300 drops → `drop_cnt` = 255. Then `clr_ovf` coinciding with a drop → `overflow` = 1, `drop_cnt` = 1. Then `clr_ovf` alone → both 0.
